// File: rtl/proc_modem_mc.sv
// proc_modem_mc - multi-channel carrier modem between DIOB pin logic and the
// virtual I/O bus.
//
// Each channel modulates tx_data onto a square-wave carrier (a 1 becomes a
// square wave with half-period 2^DIV_LOG2 clocks, a 0 becomes constant low).
// It also demodulates a received carrier by measuring synchronised run
// lengths between edges.
//
// Ports:
//   clock             in   1         system clock (125 MHz)
//   reset             in   1         asynchronous, active-high
//   i_tx_data         in   CHANNELS  per-channel bit to transmit
//   o_tx_out          out  CHANNELS  modulated line output (registered)
//   i_rx_in           in   CHANNELS  raw line input, asynchronous to clock
//   o_rx_data         out  CHANNELS  demodulated bit (decoded from lock count)
//   o_rx_err          out  CHANNELS  one-clock pulse when o_rx_data falls
//   o_output_enable   out  1         constant 1
//   o_input_enable    out  1         constant 1
module proc_modem_mc #(
  parameter int CHANNELS    = 4,
  parameter int DIV_LOG2    = 4,
  parameter int MIN_HALF    = 12,
  parameter int MAX_HALF    = 20,
  parameter int LOCK_HALVES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] i_tx_data,
  output logic [CHANNELS-1:0] o_tx_out,
  input  logic [CHANNELS-1:0] i_rx_in,
  output logic [CHANNELS-1:0] o_rx_data,
  output logic [CHANNELS-1:0] o_rx_err,
  output logic                o_output_enable,
  output logic                o_input_enable
);

  localparam int PH_W = DIV_LOG2 + 1;
  localparam int RC_W = $clog2(MAX_HALF + 2);
  localparam int VC_W = (LOCK_HALVES < 2) ? 1 : $clog2(LOCK_HALVES + 1);

  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
  localparam logic [RC_W-1:0] RC_MIN  = RC_W'(MIN_HALF);
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_HALF);
  localparam logic [RC_W-1:0] RC_SAT  = RC_W'(MAX_HALF + 1);
  localparam logic [VC_W-1:0] VC_ONE  = VC_W'(1);
  localparam logic [VC_W-1:0] VC_LOCK = VC_W'(LOCK_HALVES);

  typedef enum logic [1:0] {
    ST_STUCK = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2
  } rx_state_t;

  logic [PH_W-1:0]     r_phase;
  logic [CHANNELS-1:0] r_tx_out;
  logic [CHANNELS-1:0] r_s1;
  logic [CHANNELS-1:0] r_s2;
  logic [CHANNELS-1:0] r_s3;
  logic [CHANNELS-1:0] r_err;
  rx_state_t           r_state [CHANNELS];
  logic [RC_W-1:0]     r_rc    [CHANNELS];
  logic [VC_W-1:0]     r_vc    [CHANNELS];

  logic [CHANNELS-1:0] w_edge;
  logic [CHANNELS-1:0] w_valid;
  logic [CHANNELS-1:0] w_lock;
  logic [CHANNELS-1:0] w_timeout;
  logic [CHANNELS-1:0] w_drop;

  // Shared TX phase counter and modulator; all channels ride the same phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase  <= '0;
      r_tx_out <= '0;
    end else begin
      r_phase  <= r_phase + PH_ONE;
      r_tx_out <= i_tx_data & {CHANNELS{r_phase[DIV_LOG2]}};
    end
  end

  // Per-channel edge, half-period qualification, lock and loss decode.
  always_comb begin
    w_edge    = '0;
    w_valid   = '0;
    w_lock    = '0;
    w_timeout = '0;
    w_drop    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_edge[i]    = r_s2[i] ^ r_s3[i];
      // r_rc holds the length of the run that an edge now terminates.
      w_valid[i]   = (r_rc[i] >= RC_MIN) && (r_rc[i] <= RC_MAX);
      w_lock[i]    = (r_vc[i] == VC_LOCK);
      // Run is about to exceed MAX_HALF with no edge in sight.
      w_timeout[i] = !w_edge[i] && (r_rc[i] == RC_MAX) && (r_state[i] != ST_STUCK);
      w_drop[i]    = (w_edge[i] && !w_valid[i]) || w_timeout[i];
    end
  end

  // RX synchroniser, run counter, lock counter and per-channel state machine.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_s3  <= '0;
      r_err <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i] <= ST_STUCK;
        r_rc[i]    <= '0;
        r_vc[i]    <= '0;
      end
    end else begin
      r_s1 <= i_rx_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_edge[i]) begin
          r_rc[i] <= RC_ONE;
        end else if (r_rc[i] != RC_SAT) begin
          r_rc[i] <= r_rc[i] + RC_ONE;
        end else begin
          r_rc[i] <= r_rc[i];
        end

        // Loss of lock is known one cycle early, so the pulse lines up with
        // the falling rx_data.
        r_err[i] <= w_lock[i] & w_drop[i];

        case (r_state[i])
          ST_LOW, ST_HIGH: begin
            if (w_edge[i]) begin
              r_state[i] <= r_s2[i] ? ST_HIGH : ST_LOW;
              if (w_valid[i]) begin
                r_vc[i] <= w_lock[i] ? r_vc[i] : (r_vc[i] + VC_ONE);
              end else begin
                r_vc[i] <= '0;
              end
            end else if (w_timeout[i]) begin
              r_state[i] <= ST_STUCK;
              r_vc[i]    <= '0;
            end else begin
              r_state[i] <= r_state[i];
              r_vc[i]    <= r_vc[i];
            end
          end
          ST_STUCK: begin
            // The run leading up to this edge has no known start, so it is not measured.
            r_vc[i] <= '0;
            if (w_edge[i]) begin
              r_state[i] <= r_s2[i] ? ST_HIGH : ST_LOW;
            end else begin
              r_state[i] <= ST_STUCK;
            end
          end
          default: begin
            r_state[i] <= ST_STUCK;
            r_vc[i]    <= '0;
          end
        endcase
      end
    end
  end

  assign o_tx_out        = r_tx_out;
  assign o_rx_data       = w_lock;
  assign o_rx_err        = r_err;
  assign o_output_enable = 1'b1;
  assign o_input_enable  = 1'b1;

endmodule

// File: tb/tb_proc_modem_mc.sv
// Self-checking bench for proc_modem_mc: a timestamp-based model of the
// carrier rules checked every negedge, plus directed literal expectations.
module tb_proc_modem_mc;

  localparam int CH    = 4;
  localparam int DL    = 4;
  localparam int MINH  = 12;
  localparam int MAXH  = 20;
  localparam int LOCK  = 2;
  localparam int HALF  = 1 << DL;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] tx_data;
  logic [CH-1:0] rx_drv;
  logic          loop;
  logic [CH-1:0] tx_out;
  logic [CH-1:0] rx_data;
  logic [CH-1:0] rx_err;
  logic          oe;
  logic          ie;
  wire  [CH-1:0] rx_in = loop ? tx_out : rx_drv;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt [CH];
  bit started = 1'b0;

  // model state
  int            cyc;
  logic [CH-1:0] h0, h1, h2;
  int            last_edge [CH];
  bit            stuck [CH];
  int            vc [CH];
  logic [CH-1:0] exp_tx, exp_data, exp_err;

  proc_modem_mc #(.CHANNELS(CH), .DIV_LOG2(DL), .MIN_HALF(MINH),
                  .MAX_HALF(MAXH), .LOCK_HALVES(LOCK)) dut (
    .clock           (clock),
    .reset           (reset),
    .i_tx_data       (tx_data),
    .o_tx_out        (tx_out),
    .i_rx_in         (rx_in),
    .o_rx_data       (rx_data),
    .o_rx_err        (rx_err),
    .o_output_enable (oe),
    .o_input_enable  (ie)
  );

  always #4 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One model step per active clock edge (or reset assertion).
  task automatic model_step();
    bit was;
    int len;
    if (reset) begin
      cyc = 0; h0 = '0; h1 = '0; h2 = '0;
      exp_tx = '0; exp_data = '0; exp_err = '0;
      for (int i = 0; i < CH; i++) begin
        last_edge[i] = 0; stuck[i] = 1'b1; vc[i] = 0;
      end
    end else begin
      cyc++;
      // Counter value before this edge is cyc-1; carrier high in its upper half.
      exp_tx = tx_data & ((((cyc - 1) % (2 * HALF)) >= HALF) ? {CH{1'b1}} : {CH{1'b0}});
      for (int i = 0; i < CH; i++) begin
        was = (vc[i] == LOCK);
        // The decision logic sees the pin three clocks late.
        if (h1[i] != h2[i]) begin
          len = cyc - last_edge[i];
          if (stuck[i]) begin
            stuck[i] = 1'b0;
            vc[i] = 0;
          end else if (len >= MINH && len <= MAXH) begin
            vc[i] = (vc[i] + 1 > LOCK) ? LOCK : vc[i] + 1;
          end else begin
            vc[i] = 0;
          end
          last_edge[i] = cyc;
        end else if (!stuck[i] && (cyc - last_edge[i]) == MAXH) begin
          stuck[i] = 1'b1;
          vc[i] = 0;
        end
        exp_data[i] = (vc[i] == LOCK);
        exp_err[i]  = was && !exp_data[i];
      end
      h2 = h1; h1 = h0; h0 = rx_in;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      model_step();
    end
  end

  // Compare process: every negedge against the model.
  initial begin
    for (int i = 0; i < CH; i++) err_cnt[i] = 0;
    forever begin
      @(negedge clock);
      if (started) begin
        chk("tx_out", {28'd0, tx_out}, {28'd0, exp_tx});
        chk("rx_data", {28'd0, rx_data}, {28'd0, exp_data});
        chk("rx_err", {28'd0, rx_err}, {28'd0, exp_err});
        for (int i = 0; i < CH; i++) if (rx_err[i]) err_cnt[i]++;
      end
    end
  end

  task automatic half(input int n);
    rx_drv[1] = ~rx_drv[1];
    repeat (n) @(negedge clock);
  endtask

  // Three pin edges from STUCK; lock appears exactly 3 clocks after the third.
  task automatic acquire(input string tag);
    half(HALF);
    half(HALF);
    rx_drv[1] = ~rx_drv[1];
    @(negedge clock);
    @(negedge clock);
    chk({tag, "_pre"}, {31'd0, rx_data[1]}, 32'd0);
    @(negedge clock);
    chk({tag, "_lock"}, {31'd0, rx_data[1]}, 32'd1);
    repeat (HALF - 3) @(negedge clock);
  endtask

  int highs, others, e0;
  logic [CH-1:0] pats [4];

  initial begin
    reset = 1'b1; tx_data = '0; rx_drv = '0; loop = 1'b0;
    model_step();
    started = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_tx", {28'd0, tx_out}, 32'd0);
    chk("rst_rxd", {28'd0, rx_data}, 32'd0);
    chk("rst_err", {28'd0, rx_err}, 32'd0);
    chk("oe_ie", {30'd0, oe, ie}, 32'd3);
    reset = 1'b0;

    // 1: modulator on channel 0
    tx_data[0] = 1'b1;
    repeat (8) @(negedge clock);
    highs = 0; others = 0;
    for (int k = 0; k < 192; k++) begin
      @(negedge clock);
      if (tx_out[0]) highs++;
      if (tx_out[3:1] != 3'b000) others++;
    end
    chk("tx_duty", highs, 96);
    chk("tx_others", others, 0);
    tx_data[0] = 1'b0;
    @(negedge clock);
    chk("tx_off", {31'd0, tx_out[0]}, 32'd0);

    // 2: acquisition on channel 1
    e0 = err_cnt[1];
    acquire("acq");
    half(HALF); half(HALF);
    chk("acq_noerr", err_cnt[1] - e0, 0);

    // 3: boundaries
    e0 = err_cnt[1];
    half(12); half(20); half(HALF); half(HALF);
    chk("b12_20_hold", {31'd0, rx_data[1]}, 32'd1);
    chk("b12_20_noerr", err_cnt[1] - e0, 0);
    half(11); half(HALF);
    chk("b11_drop", {31'd0, rx_data[1]}, 32'd0);
    chk("b11_err", err_cnt[1] - e0, 1);
    half(HALF); half(HALF); half(HALF);
    chk("b11_relock", {31'd0, rx_data[1]}, 32'd1);
    half(21); half(HALF);
    chk("b21_drop", {31'd0, rx_data[1]}, 32'd0);
    chk("b21_err", err_cnt[1] - e0, 2);
    half(HALF); half(HALF); half(HALF); half(HALF);
    chk("b21_relock", {31'd0, rx_data[1]}, 32'd1);

    // 4: one-clock glitch while locked
    e0 = err_cnt[1];
    half(8); half(1); half(7);
    chk("gl_drop", {31'd0, rx_data[1]}, 32'd0);
    chk("gl_err", err_cnt[1] - e0, 1);
    half(HALF); half(HALF); half(HALF);
    chk("gl_relock", {31'd0, rx_data[1]}, 32'd1);
    chk("gl_err_once", err_cnt[1] - e0, 1);

    // 5: loopback on all channels
    loop = 1'b1;
    pats[0] = 4'b0101; pats[1] = 4'b1010; pats[2] = 4'b0110; pats[3] = 4'b1111;
    for (int p = 0; p < 4; p++) begin
      tx_data = pats[p];
      repeat (150) @(negedge clock);
      chk("loop_data", {28'd0, rx_data}, {28'd0, pats[p]});
    end

    // 6: reset while locked and transmitting
    e0 = err_cnt[1];
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tx", {28'd0, tx_out}, 32'd0);
    chk("mid_rst_rxd", {28'd0, rx_data}, 32'd0);
    chk("mid_rst_err", {28'd0, rx_err}, 32'd0);
    loop = 1'b0; tx_data = '0; rx_drv = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    acquire("racq");
    half(HALF);
    chk("rst_noerr", err_cnt[1] - e0, 0);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
